// File: rtl/conv_result_pkg.sv
// Shared types and index helpers for the conv result collector and its lane banks.
package conv_result_pkg;

   typedef enum logic {
      STATE_COLLECT = 1'b0,
      STATE_DRAIN   = 1'b1
   } state_t;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int lane_index(input int d, input int w, input int res_w);
      return d * res_w + w;
   endfunction

endpackage

// File: rtl/conv_result_bank.sv
// One result lane: a DEPTH-deep register column with one write port and a
// combinational read port.
module conv_result_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 6,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // NOTE: storage has no reset - every row is rewritten before a frame drains,
   // and non-blocking writes keep all lanes sampling the same pre-edge inputs.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en_i && (wr_addr_i == AW'(i))) begin
            mem_q[i] <= wr_data_i;
         end
      end
   end

   // NOTE: default first so the read mux can never infer a latch.
   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr_i == AW'(i)) begin
            rd_data_o = mem_q[i];
         end
      end
   end

endmodule

// File: rtl/conv_result_collector.sv
// Captures per-lane result row writes into a register frame, then drains the
// frame as a serial valid/ready stream in channel, row, column order.
module conv_result_collector
   import conv_result_pkg::*;
#(
   parameter  int DATA_WIDTH          = 8,
   parameter  int RESULT_W            = 6,
   parameter  int RESULT_H            = 6,
   parameter  int RESULT_D            = 4,
   parameter  int RESULT_H_ADDR_WIDTH = $clog2(RESULT_H),
   localparam int LANES               = RESULT_D * RESULT_W,
   localparam int CNT_WIDTH           = $clog2(LANES * RESULT_H)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [LANES*RESULT_H_ADDR_WIDTH-1:0] result_wraddress,
   input  logic [LANES*DATA_WIDTH-1:0]          result_data_out,
   input  logic [LANES-1:0]                     result_wren,
   output logic                                 rdy_frame,
   output logic [DATA_WIDTH-1:0]                out_data,
   output logic                                 out_val,
   input  logic                                 out_rdy,
   output logic                                 out_last,
   output logic                                 err_addr,
   output logic                                 err_overflow
);

   localparam int AW    = RESULT_H_ADDR_WIDTH;
   localparam int WW    = cnt_bits(RESULT_W);
   localparam int DCW   = cnt_bits(RESULT_D);
   localparam int TOTAL = LANES * RESULT_H;

   state_t                state_q, state_d;
   logic [WW-1:0]         w_q, w_d;
   logic [AW-1:0]         h_q, h_d;
   logic [DCW-1:0]        d_q, d_d;
   logic [CNT_WIDTH-1:0]  idx_q, idx_d;
   logic                  err_addr_q, err_addr_d;
   logic                  err_ovf_q, err_ovf_d;

   logic [LANES-1:0]      addr_ok;
   logic [LANES-1:0]      lane_we;
   logic [DATA_WIDTH-1:0] bank_rd [LANES];
   logic [AW-1:0]         last_addr;
   logic                  collecting;
   logic                  draining;
   logic                  frame_done;
   logic                  xfer;
   logic                  last_elem;

   assign collecting = (state_q == STATE_COLLECT);
   assign draining   = (state_q == STATE_DRAIN);
   assign last_addr  = result_wraddress[(LANES-1)*AW +: AW];
   // The engine writes lanes in lockstep, so the last lane's final row closes the frame.
   assign frame_done = collecting && result_wren[LANES-1] && (last_addr == AW'(RESULT_H - 1));
   assign xfer       = draining && out_rdy;
   assign last_elem  = (idx_q == CNT_WIDTH'(TOTAL - 1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [AW-1:0] lane_addr;
      assign lane_addr  = result_wraddress[l*AW +: AW];
      assign addr_ok[l] = int'(lane_addr) < RESULT_H;
      assign lane_we[l] = collecting && result_wren[l] && addr_ok[l];

      conv_result_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (RESULT_H),
         .AW         (AW)
      ) u_bank (
         .clk       (clk),
         .wr_en_i   (lane_we[l]),
         .wr_addr_i (lane_addr),
         .wr_data_i (result_data_out[l*DATA_WIDTH +: DATA_WIDTH]),
         .rd_addr_i (h_q),
         .rd_data_o (bank_rd[l])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= STATE_COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         STATE_COLLECT: if (frame_done)        state_d = STATE_DRAIN;
         STATE_DRAIN:   if (xfer && last_elem) state_d = STATE_COLLECT;
         default:                              state_d = STATE_COLLECT;
      endcase
   end

   // Drain counters walk w fastest, then h, then d; all wrap to zero after the last element.
   always_comb begin
      w_d   = w_q;
      h_d   = h_q;
      d_d   = d_q;
      idx_d = idx_q;
      if (xfer) begin
         idx_d = last_elem ? '0 : idx_q + CNT_WIDTH'(1);
         if (w_q == WW'(RESULT_W - 1)) begin
            w_d = '0;
            if (h_q == AW'(RESULT_H - 1)) begin
               h_d = '0;
               d_d = (d_q == DCW'(RESULT_D - 1)) ? '0 : d_q + DCW'(1);
            end else begin
               h_d = h_q + AW'(1);
            end
         end else begin
            w_d = w_q + WW'(1);
         end
      end
   end

   assign err_addr_d = err_addr_q | (collecting && |(result_wren & ~addr_ok));
   assign err_ovf_d  = err_ovf_q  | (draining && |result_wren);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_q        <= '0;
         h_q        <= '0;
         d_q        <= '0;
         idx_q      <= '0;
         err_addr_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         w_q        <= w_d;
         h_q        <= h_d;
         d_q        <= d_d;
         idx_q      <= idx_d;
         err_addr_q <= err_addr_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   // Output logic: depends only on registered state, never on result_* inputs.
   always_comb begin
      rdy_frame    = collecting;
      out_val      = draining;
      out_last     = draining && last_elem;
      err_addr     = err_addr_q;
      err_overflow = err_ovf_q;
      out_data     = '0;
      for (int l = 0; l < LANES; l++) begin
         if (l == lane_index(int'(d_q), int'(w_q), RESULT_W)) begin
            out_data = bank_rd[l];
         end
      end
   end

endmodule

// File: tb/tb_conv_result_collector.sv
// Scoreboard bench for conv_result_collector: a frame-level model predicts the
// drained stream and error flags; a monitor compares every transfer.
module tb_conv_result_collector;

   localparam int DW    = 8;
   localparam int W     = 2;
   localparam int H     = 2;
   localparam int D     = 2;
   localparam int AW    = 2;
   localparam int LANES = D * W;
   localparam int TOTAL = LANES * H;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [LANES*AW-1:0]   result_wraddress;
   logic [LANES*DW-1:0]   result_data_out;
   logic [LANES-1:0]      result_wren;
   logic                  rdy_frame;
   logic [DW-1:0]         out_data;
   logic                  out_val;
   logic                  out_rdy;
   logic                  out_last;
   logic                  err_addr;
   logic                  err_overflow;

   always #5 clk = ~clk;

   conv_result_collector #(
      .DATA_WIDTH          (DW),
      .RESULT_W            (W),
      .RESULT_H            (H),
      .RESULT_D            (D),
      .RESULT_H_ADDR_WIDTH (AW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .result_wraddress (result_wraddress),
      .result_data_out  (result_data_out),
      .result_wren      (result_wren),
      .rdy_frame        (rdy_frame),
      .out_data         (out_data),
      .out_val          (out_val),
      .out_rdy          (out_rdy),
      .out_last         (out_last),
      .err_addr         (err_addr),
      .err_overflow     (err_overflow)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [DW-1:0] ref_mem [D][W][H];
   bit            model_collect = 1'b1;
   bit            exp_err_addr  = 1'b0;
   bit            exp_err_ovf   = 1'b0;
   int            stim_addr [LANES];
   logic [DW-1:0] stim_data [LANES];
   int            total = 0;
   int            bad   = 0;
   int            xfers = 0;
   int            rdy_mode = 0;
   int            rdy_step = 0;
   bit            held_v = 1'b0;
   logic [DW-1:0] held_d;
   logic          held_l;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame order: channel outer, row middle, column inner.
   task automatic push_frame();
      for (int d = 0; d < D; d++)
         for (int h = 0; h < H; h++)
            for (int w = 0; w < W; w++)
               exp_q.push_back('{data: ref_mem[d][w][h],
                                 last: (d == D-1) && (h == H-1) && (w == W-1)});
   endtask

   // Drive one write cycle from stim_addr/stim_data, predict its effect, then release.
   task automatic apply_cycle(input logic [LANES-1:0] we);
      for (int l = 0; l < LANES; l++) begin
         result_wren[l]                   = we[l];
         result_wraddress[l*AW +: AW]     = AW'(stim_addr[l]);
         result_data_out[l*DW +: DW]      = stim_data[l];
      end
      if (model_collect) begin
         for (int l = 0; l < LANES; l++) begin
            if (we[l]) begin
               if (stim_addr[l] < H) ref_mem[l / W][l % W][stim_addr[l]] = stim_data[l];
               else                  exp_err_addr = 1'b1;
            end
         end
         if (we[LANES-1] && stim_addr[LANES-1] == H-1) begin
            model_collect = 1'b0;
            push_frame();
         end
      end else if (|we) begin
         exp_err_ovf = 1'b1;
      end
      @(posedge clk); #1;
      result_wren = '0;
   endtask

   function automatic logic [DW-1:0] pattern(input int l, input int h);
      return DW'((l / W) * 100 + (l % W) * 10 + h);
   endfunction

   task automatic write_row(input int h, input bit rnd);
      for (int l = 0; l < LANES; l++) begin
         stim_addr[l] = h;
         stim_data[l] = rnd ? DW'($urandom_range(0, 255)) : pattern(l, h);
      end
      apply_cycle('1);
   endtask

   task automatic write_frame(input bit rnd);
      for (int h = 0; h < H; h++) write_row(h, rnd);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_drain_left"}, exp_q.size(), 0);
      check({name, "_rdy_after"}, rdy_frame, 1'b1);
      check({name, "_val_after"}, out_val, 1'b0);
   endtask

   task automatic check_flags(input string name);
      check({name, "_err_addr"}, err_addr, exp_err_addr);
      check({name, "_err_ovf"}, err_overflow, exp_err_ovf);
   endtask

   task automatic model_reset();
      exp_q.delete();
      model_collect = 1'b1;
      exp_err_addr  = 1'b0;
      exp_err_ovf   = 1'b0;
   endtask

   // Downstream ready: 0 = always, 1 = 1,0,0 pattern, 2 = random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_rdy = 1'b1;
         1:       out_rdy = (rdy_step % 3 == 0);
         default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      rdy_step++;
   end

   // Monitor: compares each transfer against the scoreboard and checks stall stability.
   always @(negedge clk) begin
      if (!reset) begin
         held_v = 1'b0;
      end else begin
         if (held_v && out_val) begin
            check("hold_data", out_data, held_d);
            check("hold_last", out_last, held_l);
         end
         held_v = 1'b0;
         if (out_val) begin
            if (out_rdy) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", out_val, 1'b0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("out_data", out_data, mon_e.data);
                  check("out_last", out_last, mon_e.last);
                  if (mon_e.last) model_collect = 1'b1;
               end
               xfers++;
            end else begin
               held_v = 1'b1;
               held_d = out_data;
               held_l = out_last;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      int n;
      reset            = 1'b0;
      result_wren      = '0;
      result_wraddress = '0;
      result_data_out  = '0;
      out_rdy          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // 1: idle after reset
      check_flags("s1");
      for (int i = 0; i < 10; i++) begin
         check("s1_rdy_frame", rdy_frame, 1'b1);
         check("s1_out_val", out_val, 1'b0);
         @(posedge clk); #1;
      end
      check_flags("s1_end");

      // 2: pattern frame, always ready
      rdy_mode = 0;
      write_row(0, 1'b0);
      check("s2_val_early", out_val, 1'b0);
      check("s2_rdy_early", rdy_frame, 1'b1);
      write_row(1, 1'b0);
      check("s2_val_rise", out_val, 1'b1);
      check("s2_rdy_low", rdy_frame, 1'b0);
      wait_drain("s2");
      check_flags("s2");

      // 3: same frame with a stalling consumer
      rdy_mode = 1;
      rdy_step = 0;
      x0 = xfers;
      write_frame(1'b0);
      wait_drain("s3");
      check("s3_xfers", xfers - x0, TOTAL);

      // 4: out-of-range write mid-frame, then a clean frame
      rdy_mode = 0;
      write_row(0, 1'b0);
      for (int l = 0; l < LANES; l++) begin
         stim_addr[l] = 2;
         stim_data[l] = 8'hEE;
      end
      apply_cycle(4'b0001);
      check("s4_err_addr_set", err_addr, exp_err_addr);
      write_row(1, 1'b0);
      wait_drain("s4a");
      write_frame(1'b0);
      wait_drain("s4b");
      check_flags("s4");

      // 5: writes during drain are dropped and flagged
      rdy_mode = 2;
      write_frame(1'b0);
      for (int c = 0; c < 2; c++) begin
         for (int l = 0; l < LANES; l++) begin
            stim_addr[l] = c % H;
            stim_data[l] = 8'hFF;
         end
         apply_cycle('1);
      end
      check("s5_err_ovf_set", err_overflow, exp_err_ovf);
      wait_drain("s5");
      check_flags("s5");

      // 6: reset mid-drain, then a fresh frame drains from element 0
      rdy_mode = 0;
      x0 = xfers;
      write_frame(1'b0);
      n = 0;
      while (xfers < x0 + 3 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("s6_three_xfers", xfers - x0, 3);
      reset = 1'b0;
      #1;
      check("s6_val_in_reset", out_val, 1'b0);
      check("s6_rdy_in_reset", rdy_frame, 1'b1);
      model_reset();
      check_flags("s6_reset");
      @(posedge clk); #1;
      reset = 1'b1;
      write_frame(1'b1);
      wait_drain("s6");
      check_flags("s6");

      // 7: random frames with stray lane writes and random backpressure
      rdy_mode = 2;
      for (int f = 0; f < 6; f++) begin
         for (int h = 0; h < H; h++) begin
            if ($urandom_range(0, 1) == 1) begin
               for (int l = 0; l < LANES; l++) begin
                  stim_addr[l] = $urandom_range(0, 3);
                  stim_data[l] = DW'($urandom_range(0, 255));
               end
               apply_cycle(LANES'($urandom_range(0, (1 << (LANES-1)) - 1)));
            end
            write_row(h, 1'b1);
         end
         wait_drain("s7");
         check_flags("s7");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
